// File: rtl/ifetch_bus_bridge.sv
// Bridges the fetch stage's combinational address-to-data contract onto a valid/ready
// instruction bus, using a one-entry tagged buffer and a stall/fault handshake.
module ifetch_bus_bridge #(
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] fb_i_iaddr,
    output logic [DW-1:0] fb_o_idata,
    output logic          fb_o_stall,
    output logic          fb_o_fault,
    input  logic          fb_i_flush,
    output logic          fb_o_req_valid,
    input  logic          fb_i_req_ready,
    output logic [DW-1:0] fb_o_req_addr,
    input  logic          fb_i_rsp_valid,
    input  logic [DW-1:0] fb_i_rsp_data,
    input  logic          fb_i_rsp_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    localparam bit          TmoEn   = (TIMEOUT != 0);
    localparam logic [31:0] TmoLast = TIMEOUT - 1;

    state_e        state_q;
    logic          buf_vld_q;
    logic [DW-1:0] buf_tag_q;
    logic [DW-1:0] buf_data_q;
    logic          buf_err_q;
    logic          req_valid_q;
    logic [DW-1:0] req_addr_q;
    logic          drop_q;
    logic [31:0]   tmo_cnt_q;
    logic          tmo_flag_q;

    logic hit;
    logic misal;
    logic tmo_hit;

    assign hit     = buf_vld_q & (buf_tag_q == fb_i_iaddr) & ~fb_i_flush;
    assign misal   = (fb_i_iaddr[1:0] != 2'b00);
    assign tmo_hit = TmoEn && (tmo_cnt_q == TmoLast);

    assign fb_o_idata     = hit ? buf_data_q : '0;
    assign fb_o_stall     = ~hit | misal;
    assign fb_o_fault     = misal | (hit & buf_err_q) | tmo_flag_q;
    assign fb_o_req_valid = req_valid_q;
    assign fb_o_req_addr  = req_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            buf_vld_q   <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            buf_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            drop_q      <= 1'b0;
            tmo_cnt_q   <= '0;
            tmo_flag_q  <= 1'b0;
        end else begin
            if (fb_i_flush) begin
                buf_vld_q  <= 1'b0;
                tmo_flag_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    // A timed-out fetch stays faulted until the fetch stage flushes.
                    if (!hit && !misal && !fb_i_flush && !tmo_flag_q) begin
                        req_addr_q  <= {fb_i_iaddr[DW-1:2], 2'b00};
                        req_valid_q <= 1'b1;
                        state_q     <= StReq;
                    end
                end
                StReq: begin
                    // An issued request cannot be retracted; remember to discard its data.
                    if (fb_i_flush) drop_q <= 1'b1;
                    if (fb_i_req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    if (fb_i_rsp_valid) begin
                        if (!drop_q && !fb_i_flush) begin
                            buf_vld_q  <= 1'b1;
                            buf_tag_q  <= req_addr_q;
                            buf_data_q <= fb_i_rsp_err ? '0 : fb_i_rsp_data;
                            buf_err_q  <= fb_i_rsp_err;
                        end
                        drop_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmo_hit) begin
                        tmo_flag_q <= ~fb_i_flush;
                        drop_q     <= 1'b0;
                        state_q    <= StIdle;
                    end else if (fb_i_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_bus_bridge.sv
// Directed bench for ifetch_bus_bridge: a scoreboard queue holds the word and fault each
// fetch should deliver, popped when the bridge releases stall.
module tb_ifetch_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        stall;
    logic        fault;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   lat;

    ifetch_bus_bridge #(
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fb_i_iaddr     (iaddr),
        .fb_o_idata     (idata),
        .fb_o_stall     (stall),
        .fb_o_fault     (fault),
        .fb_i_flush     (flush),
        .fb_o_req_valid (req_valid),
        .fb_i_req_ready (req_ready),
        .fb_o_req_addr  (req_addr),
        .fb_i_rsp_valid (rsp_valid),
        .fb_i_rsp_data  (rsp_data),
        .fb_i_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " req_valid"}, 32'(req_valid), 32'd1);
    endtask

    task automatic accept(input string tag);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk({tag, " req_valid drop"}, 32'(req_valid), 32'd0);
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        rsp_valid = 1'b1;
        rsp_data  = data;
        rsp_err   = err;
        step();
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
    endtask

    task automatic expect_hit(input string tag);
        int   n = 0;
        exp_t e;
        while (stall && n < 20) begin
            step();
            n++;
        end
        chk({tag, " stall"}, 32'(stall), 32'd0);
        n_tests++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " addr"}, iaddr, e.addr);
            chk({tag, " idata"}, idata, e.data);
            chk({tag, " fault"}, 32'(fault), 32'(e.fault));
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, input int rdly, output int latency);
        int start;
        iaddr = addr;
        sb.push_back('{addr: addr, data: (err ? 32'd0 : data), fault: err});
        start     = cyc;
        req_ready = (rdly == 0);
        wait_req(tag);
        chk({tag, " req_addr"}, req_addr, addr);
        for (int i = 0; i < rdly; i++) begin
            step();
            chk({tag, " bp req_valid"}, 32'(req_valid), 32'd1);
            chk({tag, " bp req_addr"}, req_addr, addr);
        end
        accept(tag);
        respond(data, err);
        expect_hit(tag);
        latency = cyc - start;
    endtask

    initial begin
        rst_n     = 1'b0;
        iaddr     = 32'h0800_0000;
        flush     = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        #12;
        chk("reset stall", 32'(stall), 32'd1);
        chk("reset req_valid", 32'(req_valid), 32'd0);
        chk("reset req_addr", req_addr, 32'd0);
        chk("reset idata", idata, 32'd0);
        chk("reset fault", 32'(fault), 32'd0);

        // Minimum-latency miss straight out of reset.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fetch("first", 32'h0800_0000, 32'h0000_0093, 1'b0, 0, lat);
        chk("first latency", 32'(lat), 32'd3);
        iaddr = 32'h0800_0004;
        #1;
        chk("next miss stall", 32'(stall), 32'd1);
        chk("next miss idata", idata, 32'd0);
        fetch("next", 32'h0800_0004, 32'h0000_0113, 1'b0, 0, lat);

        // Backpressure: ready held low for four cycles.
        fetch("bp", 32'h0800_0008, 32'hCAFE_F00D, 1'b0, 4, lat);
        chk("bp latency", 32'(lat), 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp single req", 32'(req_valid), 32'd0);
            chk("bp hit held", 32'(stall), 32'd0);
        end

        // Flush while waiting: the returning word must be discarded.
        iaddr = 32'h0800_0010;
        sb.push_back('{addr: 32'h0800_0010, data: 32'h0000_A5A5, fault: 1'b0});
        req_ready = 1'b1;
        wait_req("flush");
        chk("flush req_addr", req_addr, 32'h0800_0010);
        accept("flush");
        flush = 1'b1;
        step();
        flush = 1'b0;
        respond(32'hDEAD_BEEF, 1'b0);
        chk("flush dropped stall", 32'(stall), 32'd1);
        chk("flush dropped idata", idata, 32'd0);
        wait_req("refetch");
        chk("refetch req_addr", req_addr, 32'h0800_0010);
        accept("refetch");
        respond(32'h0000_A5A5, 1'b0);
        expect_hit("refetch");

        // Bus error: hit with zero data and fault.
        fetch("err", 32'h0800_0020, 32'h1234_5678, 1'b1, 0, lat);

        // Timeout after eight WAIT cycles with no response.
        iaddr = 32'h0800_0030;
        sb.push_back('{addr: 32'h0800_0030, data: 32'h0BAD_CAFE, fault: 1'b0});
        req_ready = 1'b1;
        wait_req("tmo");
        accept("tmo");
        for (int i = 1; i < 8; i++) begin
            step();
            chk("tmo early fault", 32'(fault), 32'd0);
        end
        step();
        chk("tmo fault", 32'(fault), 32'd1);
        chk("tmo stall", 32'(stall), 32'd1);
        step();
        chk("tmo fault sticky", 32'(fault), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("tmo flush clears", 32'(fault), 32'd0);
        wait_req("retry");
        chk("retry req_addr", req_addr, 32'h0800_0030);
        accept("retry");
        respond(32'h0BAD_CAFE, 1'b0);
        expect_hit("retry");

        // Misaligned address never reaches the bus.
        iaddr = 32'h0800_0002;
        #1;
        chk("misal stall", 32'(stall), 32'd1);
        chk("misal fault", 32'(fault), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("misal no req", 32'(req_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a stalled request.
        iaddr     = 32'h0800_0040;
        req_ready = 1'b0;
        wait_req("rst");
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst req_valid", 32'(req_valid), 32'd0);
        chk("rst req_addr", req_addr, 32'd0);
        step();
        rst_n = 1'b1;
        iaddr = 32'h0800_0030;
        #1;
        chk("rst buffer cleared", 32'(stall), 32'd1);
        chk("rst idata", idata, 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
